// File: rtl/race_controller.sv
// Reaction-race controller: 3-2-1 countdown, then player key presses race a PC pacer.
// Optional player-key debouncer enabled by defining RACE_KEY_DEBOUNCE_EN.
module race_controller #(
    parameter int unsigned CD_DIV     = 50000000,
    parameter int unsigned PC_DIV     = 25000000,
    parameter int unsigned DEB_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start_key,
    input  logic       player_key,
    input  logic       player_ended,
    input  logic       pc_ended,
    output logic       player_dec,
    output logic       pc_dec,
    output logic       score_clr_n,
    output logic [1:0] countdown,
    output logic       racing,
    output logic [1:0] winner
);

    localparam int unsigned CdW = (CD_DIV > 1) ? $clog2(CD_DIV) : 1;
    localparam int unsigned PcW = (PC_DIV > 1) ? $clog2(PC_DIV) : 1;
    localparam logic [CdW-1:0] CdMax = CdW'(CD_DIV - 1);
    localparam logic [PcW-1:0] PcMax = PcW'(PC_DIV - 1);

    typedef enum logic [1:0] {StIdle, StCount, StRace, StDone} state_e;

    state_e           state_q;
    logic [CdW-1:0]   cd_cnt_q;
    logic [PcW-1:0]   pc_cnt_q;
    logic [1:0]       start_sync_q;
    logic [1:0]       player_sync_q;
    logic             start_prev_q;
    logic             player_prev_q;
    logic             player_level;
    logic             start_pulse;
    logic             player_pulse;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            start_sync_q  <= '0;
            player_sync_q <= '0;
            start_prev_q  <= 1'b0;
            player_prev_q <= 1'b0;
        end else begin
            start_sync_q  <= {start_sync_q[0], start_key};
            player_sync_q <= {player_sync_q[0], player_key};
            start_prev_q  <= start_sync_q[1];
            player_prev_q <= player_level;
        end
    end

`ifdef RACE_KEY_DEBOUNCE_EN
    localparam int unsigned DbW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DbW-1:0] DbMax = DbW'(DEB_CYCLES - 1);

    logic [DbW-1:0] deb_cnt_q;
    logic           deb_level_q;

    // Counts consecutive cycles the synced key disagrees with the debounced level.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            deb_cnt_q   <= '0;
            deb_level_q <= 1'b0;
        end else if (player_sync_q[1] == deb_level_q) begin
            deb_cnt_q <= '0;
        end else if (deb_cnt_q == DbMax) begin
            deb_cnt_q   <= '0;
            deb_level_q <= player_sync_q[1];
        end else begin
            deb_cnt_q <= deb_cnt_q + DbW'(1);
        end
    end

    assign player_level = deb_level_q;
`else
    assign player_level = player_sync_q[1];
`endif

    assign start_pulse  = start_sync_q[1] & ~start_prev_q;
    assign player_pulse = player_level & ~player_prev_q;
    assign racing       = (state_q == StRace);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            countdown   <= 2'd0;
            winner      <= 2'b00;
            player_dec  <= 1'b0;
            pc_dec      <= 1'b0;
            score_clr_n <= 1'b0;
            cd_cnt_q    <= '0;
            pc_cnt_q    <= '0;
        end else begin
            player_dec <= 1'b0;
            pc_dec     <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_pulse) begin
                        state_q   <= StCount;
                        countdown <= 2'd3;
                        cd_cnt_q  <= '0;
                    end
                end
                StCount: begin
                    if (cd_cnt_q == CdMax) begin
                        cd_cnt_q  <= '0;
                        countdown <= countdown - 2'd1;
                        // Countdown hits 0 on the same edge the race begins.
                        if (countdown == 2'd1) begin
                            state_q     <= StRace;
                            score_clr_n <= 1'b1;
                            pc_cnt_q    <= '0;
                        end
                    end else begin
                        cd_cnt_q <= cd_cnt_q + CdW'(1);
                    end
                end
                StRace: begin
                    if (player_ended || pc_ended) begin
                        state_q <= StDone;
                        winner  <= {pc_ended, player_ended};
                    end else begin
                        player_dec <= player_pulse;
                        if (pc_cnt_q == PcMax) begin
                            pc_cnt_q <= '0;
                            pc_dec   <= 1'b1;
                        end else begin
                            pc_cnt_q <= pc_cnt_q + PcW'(1);
                        end
                    end
                end
                StDone: begin
                    if (start_pulse) begin
                        state_q     <= StCount;
                        countdown   <= 2'd3;
                        winner      <= 2'b00;
                        score_clr_n <= 1'b0;
                        cd_cnt_q    <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_race_controller.sv
// Randomized bench for race_controller against a cycle-count based reference model.
module tb_race_controller;

    localparam int CD_DIV     = 4;
    localparam int PC_DIV     = 10;
    localparam int DEB_CYCLES = 3;

    localparam int PIdle  = 0;
    localparam int PCount = 1;
    localparam int PRace  = 2;
    localparam int PDone  = 3;

    logic       clk          = 1'b0;
    logic       resetn       = 1'b1;
    logic       start_key    = 1'b0;
    logic       player_key   = 1'b0;
    logic       player_ended = 1'b0;
    logic       pc_ended     = 1'b0;
    logic       player_dec;
    logic       pc_dec;
    logic       score_clr_n;
    logic [1:0] countdown;
    logic       racing;
    logic [1:0] winner;

    int checks   = 0;
    int failures = 0;

    // Reference model: phase plus cycles spent in it, and raw key sample history.
    int         m_phase;
    int         m_t;
    logic [1:0] m_win;
    logic       m_pdec;
    logic       m_cdec;
    logic [3:0] m_hs;
    logic [3:0] m_hp;
    logic       m_prev_lvl;
    logic       m_lvl;
    logic       m_last_sync;
    int         m_run;

    race_controller #(
        .CD_DIV    (CD_DIV),
        .PC_DIV    (PC_DIV),
        .DEB_CYCLES(DEB_CYCLES)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start_key   (start_key),
        .player_key  (player_key),
        .player_ended(player_ended),
        .pc_ended    (pc_ended),
        .player_dec  (player_dec),
        .pc_dec      (pc_dec),
        .score_clr_n (score_clr_n),
        .countdown   (countdown),
        .racing      (racing),
        .winner      (winner)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase     = PIdle;
        m_t         = 0;
        m_win       = 2'b00;
        m_pdec      = 1'b0;
        m_cdec      = 1'b0;
        m_hs        = '0;
        m_hp        = '0;
        m_prev_lvl  = 1'b0;
        m_lvl       = 1'b0;
        m_last_sync = 1'b0;
        m_run       = 0;
    endtask

    task automatic model_step();
        logic start_p;
        logic sync_p;
        logic lvl_now;
        logic player_p;
        m_hs = {m_hs[2:0], start_key};
        m_hp = {m_hp[2:0], player_key};
        // A key seen high at edge n-2 but low at n-3 is an edge acted on at edge n.
        start_p = m_hs[2] & ~m_hs[3];
        sync_p  = m_hp[2];
`ifdef RACE_KEY_DEBOUNCE_EN
        lvl_now = m_lvl;
        if (sync_p == m_last_sync) begin
            if (m_run < DEB_CYCLES) m_run++;
        end else begin
            m_run = 1;
        end
        m_last_sync = sync_p;
        if (m_run >= DEB_CYCLES) m_lvl = sync_p;
`else
        lvl_now = sync_p;
`endif
        player_p   = lvl_now & ~m_prev_lvl;
        m_prev_lvl = lvl_now;

        m_pdec = 1'b0;
        m_cdec = 1'b0;
        case (m_phase)
            PIdle: begin
                if (start_p) begin
                    m_phase = PCount;
                    m_t     = 0;
                end
            end
            PCount: begin
                m_t++;
                if (m_t == 3 * CD_DIV) begin
                    m_phase = PRace;
                    m_t     = 0;
                end
            end
            PRace: begin
                if (player_ended || pc_ended) begin
                    m_phase = PDone;
                    m_win   = {pc_ended, player_ended};
                end else begin
                    m_t++;
                    m_cdec = ((m_t % PC_DIV) == 0);
                    m_pdec = player_p;
                end
            end
            default: begin
                if (start_p) begin
                    m_phase = PCount;
                    m_t     = 0;
                    m_win   = 2'b00;
                end
            end
        endcase
    endtask

    task automatic check_outputs();
        int exp_cd;
        exp_cd = (m_phase == PCount) ? 3 - m_t / CD_DIV : 0;
        check_eq("player_dec", 32'(player_dec), 32'(m_pdec));
        check_eq("pc_dec", 32'(pc_dec), 32'(m_cdec));
        check_eq("score_clr_n", 32'(score_clr_n), 32'(m_phase >= PRace));
        check_eq("countdown", 32'(countdown), 32'(exp_cd));
        check_eq("racing", 32'(racing), 32'(m_phase == PRace));
        check_eq("winner", 32'(winner), 32'(m_win));
    endtask

    task automatic tick();
        @(posedge clk);
        if (resetn) model_step();
        @(negedge clk);
        check_outputs();
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear without a clock edge.
    task automatic apply_reset();
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        check_outputs();
        repeat (2) tick();
        resetn = 1'b1;
    endtask

    initial begin
        int start_hold;
        int key_hold;
        model_reset();
        apply_reset();
        start_hold = 0;
        key_hold   = 0;
        for (int i = 0; i < 6000; i++) begin
            if (start_hold > 0) begin
                start_key = 1'b1;
                start_hold--;
            end else begin
                start_key = 1'b0;
                if ($urandom_range(0, 39) == 0) start_hold = $urandom_range(1, 4);
            end

            if (key_hold > 0) begin
                key_hold--;
            end else begin
                player_key = ~player_key;
                key_hold   = $urandom_range(0, 12);
            end

            player_ended = 1'b0;
            pc_ended     = 1'b0;
            if ((m_phase == PRace && $urandom_range(0, 59) == 0) ||
                (m_phase != PRace && $urandom_range(0, 29) == 0)) begin
                {pc_ended, player_ended} = 2'($urandom_range(1, 3));
            end

            if (m_phase == PRace && $urandom_range(0, 299) == 0) begin
                player_key = 1'b1;
                key_hold   = 20;
                tick();
                apply_reset();
            end else begin
                tick();
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
